// File: rtl/tone_pkg.sv
// Shared widths, config selectors and wave type encodings
// for the tone voice scheduler.
package tone_pkg;

  localparam int LUT_ADDR_W  = 4;
  localparam int SAMPLE_W    = 4;
  localparam int WAVE_TYPE_W = 3;

  localparam logic CFG_SEL_PERIOD = 1'b0;
  localparam logic CFG_SEL_TYPE   = 1'b1;

  typedef enum logic [WAVE_TYPE_W-1:0] {
    SQR_50   = 3'd0,
    SQR_12   = 3'd1,
    SQR_25   = 3'd2,
    SQR_37   = 3'd3,
    MEM_NORM = 3'd4,
    MEM_REV  = 3'd5,
    MEM_LO   = 3'd6,
    MEM_HI   = 3'd7
  } wave_type_e;

  function automatic logic is_mem_wave(
    input logic [WAVE_TYPE_W-1:0] t
  );
    return t[WAVE_TYPE_W-1];
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One voice: period, divider counter, phase, wave type, enable.
// Advances only on the clock where its slot is active.
module tone_voice
  import tone_pkg::*;
#(
  parameter int DIV_W = 12
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   step,
  input  logic                   period_we,
  input  logic                   type_we,
  input  logic [DIV_W-1:0]       cfg_data,
  output logic [LUT_ADDR_W-1:0]  phase,
  output logic [WAVE_TYPE_W-1:0] wave_type,
  output logic                   enable
);

  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] count;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      period    <= '0;
      count     <= '0;
      phase     <= '0;
      wave_type <= '0;
      enable    <= 1'b0;
    end else begin
      if (step && enable) begin
        if (count == '0) begin
          phase <= phase + LUT_ADDR_W'(1);
          count <= period;
        end else begin
          count <= count - DIV_W'(1);
        end
      end
      // A period write reloads the counter but keeps any phase step
      if (period_we) begin
        period <= cfg_data;
        count  <= cfg_data;
      end
      if (type_we) begin
        wave_type <= cfg_data[WAVE_TYPE_W-1:0];
        enable    <= cfg_data[3];
        if (enable && !cfg_data[3]) begin
          phase <= '0;
          count <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/tone_voice_scheduler.sv
// Round-robin voice scheduler sharing one wave lookup.
// Optional frame mixer enabled by TONE_SCHED_MIX_EN.
module tone_voice_scheduler
  import tone_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DIV_W  = 12,
  localparam int CH_W   = $clog2(NUM_CH),
  localparam int MIX_W  = SAMPLE_W + CH_W
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   cfg_we_in,
  input  logic [CH_W:0]          cfg_addr_in,
  input  logic [DIV_W-1:0]       cfg_data_in,
  input  logic                   wmem_req_in,
  input  logic [3:0]             wmem_addr_in,
  input  logic [3:0]             wmem_data_in,
  output logic                   wmem_ack_out,
  output logic [LUT_ADDR_W-1:0]  lut_addr_out,
  output logic [WAVE_TYPE_W-1:0] wave_type_out,
  input  logic [15:0]            lut_data_in,
  output logic [3:0]             mem_write_addr_out,
  output logic [3:0]             mem_write_data_out,
  output logic                   mem_write_en_out,
  output logic [SAMPLE_W-1:0]    sample_out,
  output logic [CH_W-1:0]        sample_ch_out,
  output logic                   sample_valid_out,
  output logic [MIX_W-1:0]       mix_out
);

  localparam logic [CH_W-1:0] LAST = CH_W'(NUM_CH - 1);

  logic [CH_W-1:0]        slot;
  logic [LUT_ADDR_W-1:0]  phase [NUM_CH];
  logic [WAVE_TYPE_W-1:0] wtype [NUM_CH];
  logic [NUM_CH-1:0]      en;
  logic [CH_W-1:0]        cfg_ch;
  logic                   cfg_sel;
  logic [SAMPLE_W-1:0]    cur_sample;
  logic                   wr_go;
  logic                   unused_lut;

  assign cfg_ch  = cfg_addr_in[CH_W:1];
  assign cfg_sel = cfg_addr_in[0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
    tone_voice #(.DIV_W(DIV_W)) u_voice (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .step      (slot == CH_W'(g)),
      .period_we (cfg_we_in && cfg_ch == CH_W'(g)
                  && cfg_sel == CFG_SEL_PERIOD),
      .type_we   (cfg_we_in && cfg_ch == CH_W'(g)
                  && cfg_sel == CFG_SEL_TYPE),
      .cfg_data  (cfg_data_in),
      .phase     (phase[g]),
      .wave_type (wtype[g]),
      .enable    (en[g])
    );
  end

  assign lut_addr_out  = phase[slot];
  assign wave_type_out = wtype[slot];
  assign unused_lut    = ^lut_data_in[11:1];

  always_comb begin
    cur_sample = '0;
    if (en[slot]) begin
      if (is_mem_wave(wtype[slot]))
        cur_sample = lut_data_in[15 -: SAMPLE_W];
      else
        cur_sample = {SAMPLE_W{lut_data_in[0]}};
    end
  end

  // Memory writes only land in the last slot, between frames
  assign wr_go              = wmem_req_in && slot == LAST;
  assign wmem_ack_out       = wr_go;
  assign mem_write_en_out   = wr_go;
  assign mem_write_addr_out = wr_go ? wmem_addr_in : '0;
  assign mem_write_data_out = wr_go ? wmem_data_in : '0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot             <= '0;
      sample_out       <= '0;
      sample_ch_out    <= '0;
      sample_valid_out <= 1'b0;
    end else begin
      slot             <= (slot == LAST) ? '0 : slot + CH_W'(1);
      sample_out       <= cur_sample;
      sample_ch_out    <= slot;
      sample_valid_out <= 1'b1;
    end
  end

`ifdef TONE_SCHED_MIX_EN
  logic [MIX_W-1:0] acc;
  logic [MIX_W-1:0] mix_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc   <= '0;
      mix_q <= '0;
    end else begin
      if (slot == '0)
        acc <= MIX_W'(cur_sample);
      else
        acc <= acc + MIX_W'(cur_sample);
      if (slot == LAST)
        mix_q <= acc + MIX_W'(cur_sample);
    end
  end

  assign mix_out = mix_q;
`else
  assign mix_out = '0;
`endif

endmodule

// File: tb/tb_tone_voice_scheduler.sv
// Randomized bench for tone_voice_scheduler against a
// frame-level voice model and an emulated wave lookup.
module tb_tone_voice_scheduler;

  localparam int N = 4;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        cfg_we_in;
  logic [2:0]  cfg_addr_in;
  logic [11:0] cfg_data_in;
  logic        wmem_req_in;
  logic [3:0]  wmem_addr_in;
  logic [3:0]  wmem_data_in;
  logic        wmem_ack_out;
  logic [3:0]  lut_addr_out;
  logic [2:0]  wave_type_out;
  logic [15:0] lut_data_in;
  logic [3:0]  mem_write_addr_out;
  logic [3:0]  mem_write_data_out;
  logic        mem_write_en_out;
  logic [3:0]  sample_out;
  logic [1:0]  sample_ch_out;
  logic        sample_valid_out;
  logic [5:0]  mix_out;

  tone_voice_scheduler dut (
    .clk_in             (clk_in),
    .rst_n_in           (rst_n_in),
    .cfg_we_in          (cfg_we_in),
    .cfg_addr_in        (cfg_addr_in),
    .cfg_data_in        (cfg_data_in),
    .wmem_req_in        (wmem_req_in),
    .wmem_addr_in       (wmem_addr_in),
    .wmem_data_in       (wmem_data_in),
    .wmem_ack_out       (wmem_ack_out),
    .lut_addr_out       (lut_addr_out),
    .wave_type_out      (wave_type_out),
    .lut_data_in        (lut_data_in),
    .mem_write_addr_out (mem_write_addr_out),
    .mem_write_data_out (mem_write_data_out),
    .mem_write_en_out   (mem_write_en_out),
    .sample_out         (sample_out),
    .sample_ch_out      (sample_ch_out),
    .sample_valid_out   (sample_valid_out),
    .mix_out            (mix_out)
  );

  always #5 clk_in = ~clk_in;

  // emulated wave lookup and wave memory
  logic [3:0]  tb_mem [16] = '{default: 4'h0};
  logic [15:0] junk = 16'h0;

  function automatic logic sqr_bit(input logic [2:0] t,
                                   input logic [3:0] a);
    case (t[1:0])
      2'd0:    return a >= 4'd8;
      2'd1:    return a >= 4'd14;
      2'd2:    return a >= 4'd12;
      default: return a >= 4'd10;
    endcase
  endfunction

  always_comb begin
    if (wave_type_out[2])
      lut_data_in = {tb_mem[lut_addr_out], junk[11:0]};
    else
      lut_data_in = {junk[15:1], sqr_bit(wave_type_out, lut_addr_out)};
  end

  always @(posedge clk_in)
    if (mem_write_en_out)
      tb_mem[mem_write_addr_out] <= mem_write_data_out;

  // reference model
  int m_p [N], m_cnt [N], m_ph [N], m_ty [N], m_fs [N];
  bit m_en [N];
  int m_mem [16];
  int m_slot, m_samp, m_ch, m_valid, m_mix;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit ack_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < N; v++) begin
      m_p[v] = 0; m_cnt[v] = 0; m_ph[v] = 0;
      m_ty[v] = 0; m_en[v] = 0; m_fs[v] = 0;
    end
    m_slot = 0; m_samp = 0; m_ch = 0; m_valid = 0; m_mix = 0;
  endtask

  function automatic int model_sample(input int v);
    if (!m_en[v]) return 0;
    if (m_ty[v] >= 4) return m_mem[m_ph[v]];
    return sqr_bit(3'(m_ty[v]), 4'(m_ph[v])) ? 15 : 0;
  endfunction

  task automatic model_edge();
    int v, w, s;
    v = m_slot;
    s = model_sample(v);
    m_fs[v] = s;
    m_samp = s;
    m_ch = v;
    m_valid = 1;
    if (v == N - 1) m_mix = m_fs[0] + m_fs[1] + m_fs[2] + m_fs[3];
    if (m_en[v]) begin
      if (m_cnt[v] == 0) begin
        m_ph[v] = (m_ph[v] + 1) % 16;
        m_cnt[v] = m_p[v];
      end else begin
        m_cnt[v] = m_cnt[v] - 1;
      end
    end
    if (cfg_we_in) begin
      w = int'(cfg_addr_in[2:1]);
      if (cfg_addr_in[0] == 1'b0) begin
        m_p[w] = int'(cfg_data_in);
        m_cnt[w] = int'(cfg_data_in);
      end else begin
        if (m_en[w] && !cfg_data_in[3]) begin
          m_ph[w] = 0;
          m_cnt[w] = 0;
        end
        m_ty[w] = int'(cfg_data_in[2:0]);
        m_en[w] = cfg_data_in[3];
      end
    end
    if (v == N - 1 && wmem_req_in)
      m_mem[wmem_addr_in] = int'(wmem_data_in);
    m_slot = (m_slot + 1) % N;
  endtask

  task automatic check_outputs();
    bit g;
    g = wmem_req_in && m_slot == N - 1;
    chk("lut_addr", 32'(lut_addr_out), m_ph[m_slot]);
    chk("wave_type", 32'(wave_type_out), m_ty[m_slot]);
    chk("wmem_ack", 32'(wmem_ack_out), 32'(g));
    chk("mem_we", 32'(mem_write_en_out), 32'(g));
    if (g) begin
      chk("mem_addr", 32'(mem_write_addr_out), 32'(wmem_addr_in));
      chk("mem_data", 32'(mem_write_data_out), 32'(wmem_data_in));
    end
    chk("sample", 32'(sample_out), m_samp);
    chk("sample_ch", 32'(sample_ch_out), m_ch);
    chk("valid", 32'(sample_valid_out), m_valid);
`ifdef TONE_SCHED_MIX_EN
    chk("mix", 32'(mix_out), m_mix);
`else
    chk("mix", 32'(mix_out), 0);
`endif
  endtask

  // called at a falling edge with inputs set; returns at next falling edge
  task automatic step_cyc();
    junk = 16'($urandom);
    #1;
    check_outputs();
    ack_seen = wmem_ack_out;
    model_edge();
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic cfg_write(input int ch, input int sel, input int data);
    cfg_we_in = 1'b1;
    cfg_addr_in = 3'((ch << 1) | sel);
    cfg_data_in = 12'(data);
    step_cyc();
    cfg_we_in = 1'b0;
  endtask

  task automatic fill_mem(input bit all_f);
    int t, last;
    last = 0;
    for (int k = 0; k < 16; k++) begin
      wmem_req_in = 1'b1;
      wmem_addr_in = 4'(k);
      wmem_data_in = all_f ? 4'hF : 4'(k);
      t = 0;
      do begin
        step_cyc();
        t++;
      end while (!ack_seen && t < 8);
      chk("wmem_ack_wait", 32'(ack_seen), 1);
      if (k > 0) chk("ack_spacing", cyc - last, 4);
      last = cyc;
      wmem_req_in = 1'b0;
    end
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      cfg_we_in = ($urandom % 8) == 0;
      cfg_addr_in = 3'($urandom);
      if (cfg_addr_in[0])
        cfg_data_in = 12'($urandom);
      else if ($urandom % 8 == 0)
        cfg_data_in = 12'($urandom_range(0, 40));
      else
        cfg_data_in = 12'($urandom_range(0, 3));
      if (!wmem_req_in && $urandom % 3 == 0) begin
        wmem_req_in = 1'b1;
        wmem_addr_in = 4'($urandom);
        wmem_data_in = 4'($urandom);
      end
      step_cyc();
      if (ack_seen) wmem_req_in = 1'b0;
    end
    cfg_we_in = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) m_mem[k] = 0;
    rst_n_in = 1'b0;
    cfg_we_in = 1'b0; cfg_addr_in = '0; cfg_data_in = '0;
    wmem_req_in = 1'b0; wmem_addr_in = '0; wmem_data_in = '0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    // idle after reset
    repeat (8) step_cyc();

    // V0 square 50%, step every frame
    cfg_write(0, 1, 4'b1000);
    repeat (70) step_cyc();

    // memory ramp, V1 memory wave with period 2
    fill_mem(1'b0);
    cfg_write(1, 0, 2);
    cfg_write(1, 1, 4'b1100);
    repeat (100) step_cyc();

    // period write on V0's expiry slot, then disable
    while (m_slot != 0) step_cyc();
    cfg_write(0, 0, 5);
    repeat (30) step_cyc();
    cfg_write(0, 1, 4'b0000);
    repeat (8) step_cyc();

    // all voices reading 0xF
    fill_mem(1'b1);
    for (int v = 0; v < N; v++) begin
      cfg_write(v, 0, 0);
      cfg_write(v, 1, 4'b1100);
    end
    repeat (12) step_cyc();

    run_rand(1500);

    // asynchronous reset in the middle of a frame
    while (m_slot != 2) step_cyc();
    #3;
    rst_n_in = 1'b0;
    wmem_req_in = 1'b0;
    cfg_we_in = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (4) step_cyc();
    run_rand(300);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
